// File: rtl/toggle_clock_monitor.sv
// toggle_clock_monitor: synchronizes a divided clock, strobes its edges, measures half-periods and tracks lock/loss.
module toggle_clock_monitor #(
  parameter int SIZE       = 26,
  parameter int EXPECTED   = 25000000,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 50000000,
  parameter int LOCK_COUNT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            slow_in,
  output logic            rise_pulse,
  output logic            fall_pulse,
  output logic [SIZE-1:0] half_period,
  output logic            meas_valid,
  output logic            locked,
  output logic            lost
);
  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED, LOST} state_t;
  localparam logic [SIZE:0]   EXP_W  = (SIZE+1)'(EXPECTED);
  localparam logic [SIZE:0]   TOL_W  = (SIZE+1)'(TOL);
  localparam logic [SIZE-1:0] TO_W   = SIZE'(TIMEOUT - 1);
  localparam logic [3:0]      LOCK_W = 4'(LOCK_COUNT);
  state_t state, state_nx;
  logic s1, s2, p;
  logic [SIZE-1:0] cnt;
  logic [3:0] match, match_nx;
  logic [SIZE:0] m, diff;
  logic edge_det, in_tol, timeout, measure;
  // one extra bit keeps cnt+1 and the deviation free of overflow
  assign m        = {1'b0, cnt} + (SIZE+1)'(1);
  assign diff     = m >= EXP_W ? m - EXP_W : EXP_W - m;
  assign in_tol   = diff <= TOL_W;
  assign edge_det = s2 ^ p;
  assign timeout  = !edge_det && cnt == TO_W;
  assign measure  = edge_det && (state == LOCKING || state == LOCKED);
  always_comb begin
    state_nx = state;
    match_nx = match;
    if (edge_det) begin
      if (state == SEARCH || state == LOST || !in_tol) begin
        state_nx = LOCKING;
        match_nx = '0;
      end else if (state == LOCKING) begin
        match_nx = match + 4'd1;
        state_nx = match_nx == LOCK_W ? LOCKED : LOCKING;
      end
    end else if (timeout) begin
      state_nx = LOST;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      p           <= 1'b0;
      cnt         <= '0;
      match       <= '0;
      state       <= SEARCH;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      s1          <= slow_in;
      s2          <= s1;
      p           <= s2;
      cnt         <= edge_det ? '0 : (&cnt ? cnt : cnt + SIZE'(1));
      match       <= match_nx;
      state       <= state_nx;
      rise_pulse  <= s2 & !p;
      fall_pulse  <= !s2 & p;
      meas_valid  <= measure;
      half_period <= measure ? (m[SIZE] ? '1 : m[SIZE-1:0]) : half_period;
      locked      <= state_nx == LOCKED;
      lost        <= state_nx == LOST;
    end
  end
endmodule

// File: tb/tb_toggle_clock_monitor.sv
// tb_toggle_clock_monitor: directed checks of strobes, measurement, lock, timeout and async reset.
module tb_toggle_clock_monitor;
  logic clock = 1'b0;
  logic reset;
  logic slow_in;
  logic rise_pulse, fall_pulse, meas_valid, locked, lost;
  logic [7:0] half_period;
  int checks = 0;
  int errors = 0;
  toggle_clock_monitor #(.SIZE(8), .EXPECTED(10), .TOL(1), .TIMEOUT(32), .LOCK_COUNT(3)) dut (
    .clock(clock), .reset(reset), .slow_in(slow_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_period(half_period),
    .meas_valid(meas_valid), .locked(locked), .lost(lost)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_rise"}, int'(rise_pulse), 0);
    chk({tag, "_fall"}, int'(fall_pulse), 0);
    chk({tag, "_mv"}, int'(meas_valid), 0);
    chk({tag, "_hp"}, int'(half_period), 0);
    chk({tag, "_lock"}, int'(locked), 0);
    chk({tag, "_lost"}, int'(lost), 0);
  endtask
  // toggle at a negedge; strobe appears after the third following posedge, then hold n cycles total
  task automatic toggle(input string tag, input bit mv, input int hp, input bit lk, input bit ls, input int n);
    slow_in = ~slow_in;
    step(2);
    chk({tag, "_early"}, int'(rise_pulse | fall_pulse), 0);
    step(1);
    chk({tag, "_rise"}, int'(rise_pulse), int'(slow_in));
    chk({tag, "_fall"}, int'(fall_pulse), int'(!slow_in));
    chk({tag, "_mv"}, int'(meas_valid), int'(mv));
    if (mv) chk({tag, "_hp"}, int'(half_period), hp);
    chk({tag, "_lock"}, int'(locked), int'(lk));
    chk({tag, "_lost"}, int'(lost), int'(ls));
    step(1);
    chk({tag, "_once"}, int'(rise_pulse | fall_pulse | meas_valid), 0);
    if (n > 4) step(n - 4);
  endtask
  initial begin
    slow_in = 1'b0;
    reset = 1'b1;
    #1 all_zero("rst0");
    step(3);
    all_zero("rst_hold");
    reset = 1'b0;
    step(5);
    all_zero("idle");
    toggle("e1", 0, 0, 0, 0, 10);
    toggle("e2", 1, 10, 0, 0, 10);
    toggle("e3", 1, 10, 0, 0, 10);
    toggle("e4", 1, 10, 1, 0, 10);
    toggle("e5", 1, 10, 1, 0, 13);
    toggle("e6_long", 1, 13, 0, 0, 10);
    toggle("e7", 1, 10, 0, 0, 10);
    toggle("e8", 1, 10, 0, 0, 10);
    toggle("e9_relock", 1, 10, 1, 0, 13);
    toggle("e10", 1, 13, 0, 0, 9);
    toggle("e11_h9", 1, 9, 0, 0, 11);
    toggle("e12_h11", 1, 11, 0, 0, 10);
    toggle("e13_h10", 1, 10, 1, 0, 13);
    toggle("e14", 1, 13, 0, 0, 10);
    toggle("e15", 1, 10, 0, 0, 12);
    toggle("e16_h12", 1, 12, 0, 0, 10);
    toggle("e17", 1, 10, 0, 0, 10);
    toggle("e18_nolock", 1, 10, 0, 0, 10);
    toggle("e19_lock", 1, 10, 1, 0, 4);
    step(30);
    chk("to_before_lost", int'(lost), 0);
    chk("to_before_lock", int'(locked), 1);
    step(1);
    chk("to_lost", int'(lost), 1);
    chk("to_lock", int'(locked), 0);
    step(5);
    toggle("e20_rearm", 0, 0, 0, 0, 10);
    toggle("e21", 1, 10, 0, 0, 10);
    toggle("e22", 1, 10, 0, 0, 10);
    toggle("e23_lock", 1, 10, 1, 0, 4);
    step(3);
    #2 reset = 1'b1;
    #1 all_zero("async_rst");
    slow_in = 1'b0;
    step(2);
    reset = 1'b0;
    step(5);
    all_zero("post_rst");
    toggle("r1", 0, 0, 0, 0, 10);
    toggle("r2", 1, 10, 0, 0, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
